// File: rtl/sysid_checker.sv
// Reads the ID and build-timestamp words from an Avalon-MM sysid slave after a start pulse.
// Compares both words against the expected values and reports sticky flags plus the captured words.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1674985676,
  parameter bit          CHECK_TS    = 1'b1,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_EVAL,
    S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  stall_q, stall_d;
  logic [7:0]  stall_inc;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stall_q    <= '0;
      pass_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      pass_q     <= pass_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Counter stops at TIMEOUT (<= 255), so the increment never wraps.
  assign stall_inc = stall_q + 8'd1;

  // NOTE: every variable gets a hold-value default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    pass_d     = pass_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          stall_d   = '0;
          state_d   = S_RD_ID;
        end
      end
      S_RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_d = avm_readdata;
          stall_d    = '0;
          state_d    = S_RD_TS;
        end else begin
          stall_d = stall_inc;
          if (stall_inc >= TIMEOUT) begin
            timeout_d = 1'b1;
            state_d   = S_FIN;
          end
        end
      end
      S_RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_d = avm_readdata;
          stall_d    = '0;
          state_d    = S_EVAL;
        end else begin
          stall_d = stall_inc;
          if (stall_inc >= TIMEOUT) begin
            timeout_d = 1'b1;
            state_d   = S_FIN;
          end
        end
      end
      S_EVAL: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TS);
        pass_d  = (id_value_q == EXPECTED_ID) &&
                  ((ts_value_q == EXPECTED_TS) || !CHECK_TS);
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus strobes decode straight from state, so they hold while stalled and drop on entry to FIN.
  assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
  assign avm_address = (state_q == S_RD_TS);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
